// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, captures instruction memory data into IF/ID,
// and handles stalls, EX redirects and the halt opcode.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [6:0]  HALT_OPCODE = 7'b1111111,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_pc_o,
    input  logic [31:0] imem_instr_i,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_instr_o,
    output logic        ifid_valid_o,
    output logic        halted_o,
    output logic [31:0] fetch_count_o
);

    typedef enum logic {RUN, HALTED} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] ifid_pc, ifid_pc_nxt;
    logic [31:0] ifid_instr, ifid_instr_nxt;
    logic        ifid_valid, ifid_valid_nxt;
    logic [31:0] fetch_count, fetch_count_nxt;

    logic        is_halt;
    logic [31:0] redirect_target;

    assign is_halt         = (imem_instr_i[6:0] == HALT_OPCODE);
    assign redirect_target = {redirect_pc_i[31:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            pc          <= RESET_PC;
            ifid_pc     <= 32'h0;
            ifid_instr  <= NOP_INSTR;
            ifid_valid  <= 1'b0;
            fetch_count <= 32'h0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            ifid_pc     <= ifid_pc_nxt;
            ifid_instr  <= ifid_instr_nxt;
            ifid_valid  <= ifid_valid_nxt;
            fetch_count <= fetch_count_nxt;
        end
    end

    // Priority is redirect > stall > normal in both states; everything holds by default.
    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        ifid_pc_nxt     = ifid_pc;
        ifid_instr_nxt  = ifid_instr;
        ifid_valid_nxt  = ifid_valid;
        fetch_count_nxt = fetch_count;

        case (state)
            RUN: begin
                if (redirect_i) begin
                    pc_nxt         = redirect_target;
                    ifid_pc_nxt    = 32'h0;
                    ifid_instr_nxt = NOP_INSTR;
                    ifid_valid_nxt = 1'b0;
                end else if (!stall_i) begin
                    ifid_pc_nxt     = pc;
                    ifid_instr_nxt  = imem_instr_i;
                    ifid_valid_nxt  = 1'b1;
                    fetch_count_nxt = fetch_count + 32'd1;
                    if (is_halt) begin
                        state_nxt = HALTED;
                    end else begin
                        pc_nxt = pc + 32'd4;
                    end
                end
            end
            HALTED: begin
                if (redirect_i) begin
                    state_nxt      = RUN;
                    pc_nxt         = redirect_target;
                    ifid_pc_nxt    = 32'h0;
                    ifid_instr_nxt = NOP_INSTR;
                    ifid_valid_nxt = 1'b0;
                end else if (!stall_i) begin
                    // Keep decode fed with bubbles once the halt word has drained.
                    ifid_pc_nxt    = 32'h0;
                    ifid_instr_nxt = NOP_INSTR;
                    ifid_valid_nxt = 1'b0;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    assign imem_pc_o     = pc;
    assign ifid_pc_o     = ifid_pc;
    assign ifid_instr_o  = ifid_instr;
    assign ifid_valid_o  = ifid_valid;
    assign halted_o      = (state == HALTED);
    assign fetch_count_o = fetch_count;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: reset, streaming fetch, stall, redirect, halt and async reset.
module tb_if_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] imem_pc_o;
    logic [31:0] imem_instr_i;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_instr_o;
    logic        ifid_valid_o;
    logic        halted_o;
    logic [31:0] fetch_count_o;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    if_fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_pc_o     (imem_pc_o),
        .imem_instr_i  (imem_instr_i),
        .ifid_pc_o     (ifid_pc_o),
        .ifid_instr_o  (ifid_instr_o),
        .ifid_valid_o  (ifid_valid_o),
        .halted_o      (halted_o),
        .fetch_count_o (fetch_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word n at byte address 4n is 32'h00n00093; address 20 holds a halt word.
    always_comb begin
        if (imem_pc_o == 32'd20) imem_instr_i = 32'h0050_007F;
        else                     imem_instr_i = ((imem_pc_o >> 2) << 20) | 32'h93;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] ipc,
                           input logic [31:0] instr, input logic vld, input logic hlt,
                           input logic [31:0] cnt);
        chk({tag, ".imem_pc"}, imem_pc_o, pc);
        chk({tag, ".ifid_pc"}, ifid_pc_o, ipc);
        chk({tag, ".ifid_instr"}, ifid_instr_o, instr);
        chk({tag, ".valid"}, {31'b0, ifid_valid_o}, {31'b0, vld});
        chk({tag, ".halted"}, {31'b0, halted_o}, {31'b0, hlt});
        chk({tag, ".count"}, fetch_count_o, cnt);
    endtask

    initial begin
        rst_n = 1'b0;
        stall_i = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = 32'h0;
        #12;
        chk_all("reset", 32'h0, 32'h0, NOP, 1'b0, 1'b0, 32'd0);
        rst_n = 1'b1;

        // Free-running fetch
        step(); chk_all("run1", 32'd4,  32'd0, 32'h0000_0093, 1'b1, 1'b0, 32'd1);
        step(); chk_all("run2", 32'd8,  32'd4, 32'h0010_0093, 1'b1, 1'b0, 32'd2);
        step(); chk_all("run3", 32'd12, 32'd8, 32'h0020_0093, 1'b1, 1'b0, 32'd3);
        step(); chk_all("run4", 32'd16, 32'd12, 32'h0030_0093, 1'b1, 1'b0, 32'd4);

        // Stall at pc=8
        pulse_reset();
        step(); step();
        chk_all("pre_stall", 32'd8, 32'd4, 32'h0010_0093, 1'b1, 1'b0, 32'd2);
        stall_i = 1'b1;
        step(); chk_all("stall1", 32'd8, 32'd4, 32'h0010_0093, 1'b1, 1'b0, 32'd2);
        step(); chk_all("stall2", 32'd8, 32'd4, 32'h0010_0093, 1'b1, 1'b0, 32'd2);
        stall_i = 1'b0;
        step(); chk_all("unstall", 32'd12, 32'd8, 32'h0020_0093, 1'b1, 1'b0, 32'd3);

        // Redirect overrides stall; low target bits cleared
        redirect_i = 1'b1; redirect_pc_i = 32'h43; stall_i = 1'b1;
        step(); chk_all("redir", 32'h40, 32'h0, NOP, 1'b0, 1'b0, 32'd3);
        redirect_i = 1'b0; stall_i = 1'b0;
        step(); chk_all("redir_fetch", 32'h44, 32'h40, 32'h0100_0093, 1'b1, 1'b0, 32'd4);

        // Halt at pc=20, with a stall while the halt word is presented
        pulse_reset();
        repeat (5) step();
        chk_all("pre_halt", 32'd20, 32'd16, 32'h0040_0093, 1'b1, 1'b0, 32'd5);
        stall_i = 1'b1;
        step(); chk_all("halt_stalled", 32'd20, 32'd16, 32'h0040_0093, 1'b1, 1'b0, 32'd5);
        stall_i = 1'b0;
        step(); chk_all("halt_cap", 32'd20, 32'd20, 32'h0050_007F, 1'b1, 1'b1, 32'd6);
        stall_i = 1'b1;
        step(); chk_all("halt_hold", 32'd20, 32'd20, 32'h0050_007F, 1'b1, 1'b1, 32'd6);
        stall_i = 1'b0;
        step(); chk_all("bubble1", 32'd20, 32'd0, NOP, 1'b0, 1'b1, 32'd6);
        step(); chk_all("bubble2", 32'd20, 32'd0, NOP, 1'b0, 1'b1, 32'd6);
        step(); chk_all("bubble3", 32'd20, 32'd0, NOP, 1'b0, 1'b1, 32'd6);

        // Redirect out of HALTED
        redirect_i = 1'b1; redirect_pc_i = 32'h8;
        step(); chk_all("unhalt", 32'd8, 32'd0, NOP, 1'b0, 1'b0, 32'd6);
        redirect_i = 1'b0;
        step(); chk_all("resume", 32'd12, 32'd8, 32'h0020_0093, 1'b1, 1'b0, 32'd7);

        // Async reset mid-stream at pc=0x1C
        redirect_i = 1'b1; redirect_pc_i = 32'h18;
        step();
        redirect_i = 1'b0;
        step(); chk_all("pre_areset", 32'h1C, 32'h18, 32'h0060_0093, 1'b1, 1'b0, 32'd8);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("areset", 32'h0, 32'h0, NOP, 1'b0, 1'b0, 32'd0);
        #1;
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
